// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath blocks.
package rsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int RSA_WIDTH = 128;

   // Bit-counter width for a WIDTH-bit multiplier scan.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/blakely_iter.sv
// One Blakely step: r' = 2r + (a_bit ? b : 0), then up to two conditional
// subtracts of n. Purely combinational.
module blakely_iter
#(
   parameter int WIDTH = 128
) (
   input  logic [WIDTH+1:0] r,
   input  logic             a_bit,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH+1:0] r_next
);

   logic [WIDTH+1:0] n_ext;
   logic [WIDTH+1:0] sum;
   logic [WIDTH+1:0] sub1;

   always_comb begin
      n_ext = {2'b00, n};
      // r < n keeps 2r + b below 3n, which fits in WIDTH+2 bits
      sum   = (r << 1) + (a_bit ? {2'b00, b} : '0);
      sub1  = (sum >= n_ext) ? (sum - n_ext) : sum;
      r_next = (sub1 >= n_ext) ? (sub1 - n_ext) : sub1;
   end

endmodule

// File: rtl/blakely_modmul.sv
// Iterative Blakely modular multiplier, result = (a*b) mod n, one bit of a per clock.
// Optional operand check enabled by defining BLAKELY_OPCHECK_EN.
module blakely_modmul
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] n_reg, n_next;
   logic [WIDTH+1:0] r_reg, r_next;
   logic [WIDTH+1:0] r_iter;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] result_reg, result_next;

   blakely_iter #(.WIDTH(WIDTH)) u_iter (
      .r      (r_reg),
      .a_bit  (a_reg[cnt_reg]),
      .b      (b_reg),
      .n      (n_reg),
      .r_next (r_iter)
   );

`ifdef BLAKELY_OPCHECK_EN
   logic err_reg, err_next;
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == DONE);
   assign result = result_reg;

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      n_next      = n_reg;
      r_next      = r_reg;
      cnt_next    = cnt_reg;
      result_next = result_reg;
`ifdef BLAKELY_OPCHECK_EN
      err_next    = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next     = a;
               b_next     = b;
               n_next     = n;
               r_next     = '0;
               cnt_next   = CW'(WIDTH - 1);
               state_next = RUN;
`ifdef BLAKELY_OPCHECK_EN
               err_next   = 1'b0;
               // Bad operands bypass the iteration and report straight away
               if ((n == '0) || (a >= n) || (b >= n)) begin
                  result_next = '0;
                  err_next    = 1'b1;
                  state_next  = DONE;
               end
`endif
            end
         end
         RUN: begin
            r_next   = r_iter;
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == '0) begin
               result_next = r_iter[WIDTH-1:0];
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         n_reg      <= '0;
         r_reg      <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
`ifdef BLAKELY_OPCHECK_EN
         err_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         n_reg      <= n_next;
         r_reg      <= r_next;
         cnt_reg    <= cnt_next;
         result_reg <= result_next;
`ifdef BLAKELY_OPCHECK_EN
         err_reg    <= err_next;
`endif
      end
   end

endmodule

// File: tb/tb_blakely_modmul.sv
// Directed and randomized checks of blakely_modmul at WIDTH=5 and WIDTH=128.
module tb_blakely_modmul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic       start5;
   logic [4:0] a5, b5, n5;
   logic       busy5, done5, err5;
   logic [4:0] result5;

   logic         start128;
   logic [127:0] a128, b128, n128;
   logic         busy128, done128, err128;
   logic [127:0] result128;

   int vectors     = 0;
   int miscompares = 0;

   blakely_modmul #(.WIDTH(5)) u_dut5 (
      .clk    (clk),
      .reset  (reset),
      .start  (start5),
      .a      (a5),
      .b      (b5),
      .n      (n5),
      .busy   (busy5),
      .done   (done5),
      .result (result5),
      .err    (err5)
   );

   blakely_modmul #(.WIDTH(128)) u_dut128 (
      .clk    (clk),
      .reset  (reset),
      .start  (start128),
      .a      (a128),
      .b      (b128),
      .n      (n128),
      .busy   (busy128),
      .done   (done128),
      .result (result128),
      .err    (err128)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One WIDTH=5 operation; exp_lat counts edges after the start edge until done shows.
   task automatic op5(input logic [4:0] ai, input logic [4:0] bi, input logic [4:0] ni,
                      input logic [4:0] exp_res, input bit chk_res, input bit exp_err,
                      input int exp_lat, input bit inject);
      int cyc;
      int busy_cnt;
      int extra;
      bit seen;
      @(negedge clk);
      a5 = ai; b5 = bi; n5 = ni; start5 = 1'b1;
      @(posedge clk);
      #1;
      start5 = 1'b0;
      a5 = ~ai; b5 = ~bi; n5 = 5'd3;
      cyc = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && cyc <= 24) begin
         @(negedge clk);
         if (busy5) busy_cnt++;
         if (done5) seen = 1'b1;
         else begin
            if (inject && cyc == 2) begin
               a5 = 5'd7; b5 = 5'd9; n5 = 5'd13; start5 = 1'b1;
            end else begin
               start5 = 1'b0;
            end
            @(posedge clk);
            cyc++;
         end
      end
      start5 = 1'b0;
      check("w5_done_seen", 128'(seen), 128'(1));
      check("w5_latency", 128'(cyc), 128'(exp_lat));
      check("w5_busy_cycles", 128'(busy_cnt), 128'(exp_lat + 1));
      if (chk_res) check("w5_result", 128'(result5), 128'(exp_res));
      check("w5_err", 128'(err5), 128'(exp_err));
      $display("w5 op a=%0d b=%0d n=%0d -> result=%0d err=%0d latency=%0d", ai, bi, ni, result5, err5, cyc);
      if (inject) begin
         extra = 0;
         repeat (15) begin
            @(negedge clk);
            if (done5) extra++;
         end
         check("w5_ignored_start_dones", 128'(extra), 128'(0));
         check("w5_result_hold", 128'(result5), 128'(exp_res));
      end
   endtask

   task automatic op128(input logic [127:0] ai, input logic [127:0] bi, input logic [127:0] ni,
                        input logic [127:0] exp_res);
      int cyc;
      bit seen;
      @(negedge clk);
      a128 = ai; b128 = bi; n128 = ni; start128 = 1'b1;
      @(posedge clk);
      #1;
      start128 = 1'b0;
      a128 = '0; b128 = '0; n128 = 128'd1;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc <= 140) begin
         @(negedge clk);
         if (done128) seen = 1'b1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      check("w128_done_seen", 128'(seen), 128'(1));
      check("w128_latency", 128'(cyc), 128'(128));
      check("w128_result", result128, exp_res);
      $display("w128 op n=%0h -> result=%0h latency=%0d", ni, result128, cyc);
   endtask

   initial begin
      logic [255:0] prod;
      logic [127:0] ra, rb, rn, rexp;

      reset = 1'b0;
      start5 = 1'b0; a5 = '0; b5 = '0; n5 = '0;
      start128 = 1'b0; a128 = '0; b128 = '0; n128 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 128'(busy5), 128'(0));
      check("rst_done", 128'(done5), 128'(0));
      check("rst_result", 128'(result5), 128'(0));
      check("rst_err", 128'(err5), 128'(0));
      check("rst_busy128", 128'(busy128), 128'(0));
      reset = 1'b1;

      op5(5'd7, 5'd9, 5'd13, 5'd11, 1'b1, 1'b0, 5, 1'b0);
      @(negedge clk);
      check("done_one_cycle", 128'(done5), 128'(0));
      check("idle_after_done", 128'(busy5), 128'(0));

      // Back-to-back: second start in the cycle right after done
      op5(5'd12, 5'd12, 5'd13, 5'd1, 1'b1, 1'b0, 5, 1'b0);
      op5(5'd30, 5'd30, 5'd31, 5'd1, 1'b1, 1'b0, 5, 1'b0);

      // Reset in RUN cycle 3 aborts the operation
      @(negedge clk);
      a5 = 5'd7; b5 = 5'd9; n5 = 5'd13; start5 = 1'b1;
      @(posedge clk);
      #1;
      start5 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 128'(busy5), 128'(0));
      check("abort_done", 128'(done5), 128'(0));
      check("abort_result", 128'(result5), 128'(0));
      $display("w5 reset during RUN -> busy=%0d done=%0d result=%0d", busy5, done5, result5);
      reset = 1'b1;
      op5(5'd7, 5'd9, 5'd13, 5'd11, 1'b1, 1'b0, 5, 1'b0);

      // Start during RUN is ignored
      op5(5'd0, 5'd9, 5'd13, 5'd0, 1'b1, 1'b0, 5, 1'b1);

`ifdef BLAKELY_OPCHECK_EN
      op5(5'd7, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 0, 1'b0);
      repeat (2) @(negedge clk);
      check("err_hold", 128'(err5), 128'(1));
      op5(5'd13, 5'd9, 5'd13, 5'd0, 1'b1, 1'b1, 0, 1'b0);
`else
      op5(5'd7, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5, 1'b0);
      op5(5'd13, 5'd9, 5'd13, 5'd0, 1'b0, 1'b0, 5, 1'b0);
`endif
      op5(5'd7, 5'd9, 5'd13, 5'd11, 1'b1, 1'b0, 5, 1'b0);

      for (int i = 0; i < 200; i++) begin
         rn = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
         ra = {$urandom, $urandom, $urandom, $urandom} % rn;
         rb = {$urandom, $urandom, $urandom, $urandom} % rn;
         prod = {128'd0, ra} * {128'd0, rb};
         prod = prod % {128'd0, rn};
         rexp = prod[127:0];
         op128(ra, rb, rn, rexp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/blakely_modmul.md
Name: blakely_modmul

Overview:
- Iterative Blakely modular multiplier: computes result = (a * b) mod n, one multiplier bit per clock.
- Sits directly downstream of the ALU dispatch in the RSA box. The ALU's encrypt/decrypt sequencing issues start with operands and consumes result on done.
- Replaces the inline per-bit Blakely logic with a self-contained, handshaked engine that modular exponentiation can call repeatedly.

Parameters:
- WIDTH, 128, operand/modulus width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets).
- start  input  1  request pulse; accepted only in IDLE.
- a  input  WIDTH  multiplicand, scanned MSB first; precondition a < n.
- b  input  WIDTH  addend operand; precondition b < n.
- n  input  WIDTH  modulus; precondition n != 0.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid in the same cycle.
- result  output  WIDTH  (a*b) mod n; holds until the next accepted start.
- err  output  1  operand-check failure flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, busy=0, done=0, result=0, err=0, r=0, bit counter=0. Reset mid-RUN aborts with no done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1: latch a, b and n into internal registers, clear r, set counter=WIDTH-1, go to RUN.
  - Later input changes do not affect the operation in flight.
- RUN: each edge performs one iteration on internal r (WIDTH+2 bits, unsigned):
  - r' = 2r + (a_lat[counter] ? b_lat : 0)
  - if r' >= n_lat then r' -= n_lat; repeat the compare/subtract once more (r' < 3n before the subtracts).
  - Then decrement counter.
  - After the iteration with counter==0, write r[WIDTH-1:0] to result and go to DONE.
- DONE: done=1 for exactly this one cycle, then IDLE.
- Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored. There is no queueing, and no restart once in DONE.
- err is cleared on every accepted start.
- Preconditions violated without the check feature: result is undefined but the FSM still completes with a normal done pulse.

Optional Feature:
- Macro: BLAKELY_OPCHECK_EN.
- Defined: at an accepted start, if n==0 or a>=n or b>=n, skip RUN and go directly to DONE, with result=0 and err=1 in the done cycle. err holds until the next accepted start.
- Undefined: no check is made, err is tied to 0, and every start takes the full RUN path.

Decomposition:
- Shared package rsa_pkg:
  - state enum type (IDLE, RUN, DONE)
  - default width constant RSA_WIDTH = 128
  - counter width computed with $clog2(WIDTH)
- One sub-module, blakely_iter: purely combinational single iteration (inputs r, a bit, b, n; output next r), instantiated once inside the FSM.

Test Plan:
- WIDTH=5, a=7, b=9, n=13, start pulse -> done exactly 5 cycles after the start edge, result=11, err=0, busy high for 6 cycles.
- WIDTH=5, a=12, b=12, n=13 -> result=1 (exercises the double subtract); then a=30, b=30, n=31 -> result=1. Issue back-to-back, with the second start on the cycle after done.
- WIDTH=5, a=0, b=9, n=13 -> result=0. Pulse start again during RUN with other operands -> ignored: exactly one done, result unchanged by the second request.
- WIDTH=128, 200 random a, b < n, n odd nonzero -> result matches a bench reference (a*b)%n; done exactly 128 cycles after each start.
- Assert reset=0 at cycle 3 of RUN -> next cycle busy=0, done=0, result=0. A new start then completes correctly (7*9 mod 13 = 11).
- BLAKELY_OPCHECK_EN defined, WIDTH=5, n=0 or a=13 with n=13 -> done one cycle after start, result=0, err=1. Macro undefined, same stimulus -> full-latency done, err=0.
